// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler for an 8-floor building simulation.
// A prescaler derived from simSpeed produces one-cycle ticks; the car FSM
// (IDLE / MOVE / DOOR) advances only on ticks and serves floor calls,
// continuing in its current direction while calls remain ahead of it.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   simState[1:0]   00 START, 01 SIM, 10 PAUSE, 11 ENDING
//   simSpeed[2:0]   tick rate select (0 slowest, 7 fastest)
//   callValid       floor-call strobe
//   callFloor[2:0]  floor of the call
//   floor[2:0]      last floor reached
//   moving          car travelling between floors
//   dirUp           travel direction (1 = up)
//   doorOpen        door open at current floor
//   pending[7:0]    outstanding call bitmap
//   arrived         one-cycle pulse on each door opening
//   served[5:0]     saturating count of door openings
module elevator_scheduler #(
  parameter int unsigned BASE_DIV     = 4,
  parameter int unsigned TRAVEL_TICKS = 2,
  parameter int unsigned DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] simState,
  input  logic [2:0] simSpeed,
  input  logic       callValid,
  input  logic [2:0] callFloor,
  output logic [2:0] floor,
  output logic       moving,
  output logic       dirUp,
  output logic       doorOpen,
  output logic [7:0] pending,
  output logic       arrived,
  output logic [5:0] served
);

  typedef enum logic [1:0] {
    SIM_START  = 2'b00,
    SIM_RUN    = 2'b01,
    SIM_PAUSE  = 2'b10,
    SIM_ENDING = 2'b11
  } sim_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_t;

  sim_t        sim;
  state_t      state_q, state_n;
  logic [15:0] presc_q, presc_n, limit;
  logic [3:0]  span;
  logic [2:0]  floor_q, floor_n;
  logic        dir_q, dir_n;
  logic [3:0]  trav_q, trav_n, door_q, door_n;
  logic [7:0]  pend_q, pend_n;
  logic        arrived_q, arrived_n;
  logic [5:0]  served_q, served_n;
  logic        tick, capture, reload, entry;
  logic        any_above, any_below, ahead, behind;

  assign sim   = sim_t'(simState);
  assign span  = 4'd8 - {1'b0, simSpeed};
  assign limit = 16'(span) * 16'(BASE_DIV) - 16'd1;
  // >= rather than == so a speed increase mid-count cannot skip the tick
  assign tick  = (sim == SIM_RUN) && (presc_q >= limit);

  assign capture   = callValid && ((sim == SIM_RUN) || (sim == SIM_PAUSE));
  assign any_above = |(pend_q & (8'hFE << floor_q));
  assign any_below = |(pend_q & ~(8'hFF << floor_q));
  assign ahead     = dir_q ? any_above : any_below;
  assign behind    = dir_q ? any_below : any_above;

  always_comb begin
    state_n   = state_q;
    presc_n   = presc_q;
    floor_n   = floor_q;
    dir_n     = dir_q;
    trav_n    = trav_q;
    door_n    = door_q;
    pend_n    = pend_q;
    arrived_n = 1'b0;
    served_n  = served_q;
    reload    = 1'b0;
    entry     = 1'b0;

    if (sim == SIM_RUN) begin
      presc_n = tick ? '0 : presc_q + 16'd1;
    end

    // A call for the floor whose door is open extends the stop instead of
    // queueing another visit.
    if (capture) begin
      if ((state_q == S_DOOR) && (callFloor == floor_q)) begin
        reload = 1'b1;
      end else begin
        pend_n[callFloor] = 1'b1;
      end
    end
    if (reload) begin
      door_n = '0;
    end

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (pend_q[floor_q]) begin
            entry = 1'b1;
          end else if (any_above) begin
            dir_n   = 1'b1;
            state_n = S_MOVE;
          end else if (any_below) begin
            dir_n   = 1'b0;
            state_n = S_MOVE;
          end
        end
        S_MOVE: begin
          if (trav_q == 4'(TRAVEL_TICKS - 1)) begin
            trav_n  = '0;
            floor_n = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
            if (pend_q[floor_n]) begin
              entry = 1'b1;
            end
          end else begin
            trav_n = trav_q + 4'd1;
          end
        end
        S_DOOR: begin
          if (!reload) begin
            if (door_q == 4'(DOOR_TICKS - 1)) begin
              if (ahead) begin
                state_n = S_MOVE;
              end else if (behind) begin
                dir_n   = ~dir_q;
                state_n = S_MOVE;
              end else begin
                state_n = S_IDLE;
              end
            end else begin
              door_n = door_q + 4'd1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // Clearing after the capture lets the arrival clear win over a same-cycle set.
    if (entry) begin
      state_n         = S_DOOR;
      door_n          = '0;
      pend_n[floor_n] = 1'b0;
      arrived_n       = 1'b1;
      served_n        = (served_q == 6'd63) ? served_q : served_q + 6'd1;
    end

    if ((sim == SIM_START) || (sim == SIM_ENDING)) begin
      state_n   = S_IDLE;
      presc_n   = '0;
      floor_n   = '0;
      dir_n     = 1'b1;
      trav_n    = '0;
      door_n    = '0;
      pend_n    = '0;
      arrived_n = 1'b0;
      served_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      trav_q    <= '0;
      door_q    <= '0;
      pend_q    <= '0;
      arrived_q <= 1'b0;
      served_q  <= '0;
    end else begin
      state_q   <= state_n;
      presc_q   <= presc_n;
      floor_q   <= floor_n;
      dir_q     <= dir_n;
      trav_q    <= trav_n;
      door_q    <= door_n;
      pend_q    <= pend_n;
      arrived_q <= arrived_n;
      served_q  <= served_n;
    end
  end

  assign floor    = floor_q;
  assign moving   = (state_q == S_MOVE);
  assign dirUp    = dir_q;
  assign doorOpen = (state_q == S_DOOR);
  assign pending  = pend_q;
  assign arrived  = arrived_q;
  assign served   = served_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Testbench for elevator_scheduler: table-driven directed vectors, a few
// multi-cycle sequences, then randomized stimulus against a tick-countdown
// reference model.
module tb_elevator_scheduler;

  localparam int BASE_DIV     = 4;
  localparam int TRAVEL_TICKS = 2;
  localparam int DOOR_TICKS   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] simState;
  logic [2:0] simSpeed;
  logic       callValid;
  logic [2:0] callFloor;
  logic [2:0] floor;
  logic       moving, dirUp, doorOpen, arrived;
  logic [7:0] pending;
  logic [5:0] served;

  elevator_scheduler #(
    .BASE_DIV    (BASE_DIV),
    .TRAVEL_TICKS(TRAVEL_TICKS),
    .DOOR_TICKS  (DOOR_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .simState (simState),
    .simSpeed (simSpeed),
    .callValid(callValid),
    .callFloor(callFloor),
    .floor    (floor),
    .moving   (moving),
    .dirUp    (dirUp),
    .doorOpen (doorOpen),
    .pending  (pending),
    .arrived  (arrived),
    .served   (served)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;
  int m_state = M_IDLE, m_floor = 0, m_dir = 1, m_left = 0, m_elapsed = 0, m_served = 0;
  int m_arr = 0;
  bit m_pend [8];
  bit cmp_en = 1'b0;

  function automatic bit any_in(input bit p[8], input int lo, input int hi);
    for (int f = lo; f <= hi; f++) if (f >= 0 && f <= 7 && p[f]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pend_val();
    int v = 0;
    for (int f = 0; f < 8; f++) if (m_pend[f]) v += (1 << f);
    return v;
  endfunction

  always @(posedge clk) begin
    bit old [8];
    bit tick, reload, arrive, ahd, bhd;
    if (rst || simState == 2'd0 || simState == 2'd3) begin
      m_state = M_IDLE; m_floor = 0; m_dir = 1; m_left = 0; m_elapsed = 0;
      m_served = 0; m_arr = 0;
      for (int f = 0; f < 8; f++) m_pend[f] = 1'b0;
    end else begin
      old = m_pend; tick = 0; reload = 0; arrive = 0; m_arr = 0;
      if (simState == 2'd1) begin
        if (m_elapsed + 1 >= (8 - int'(simSpeed)) * BASE_DIV) begin
          tick = 1; m_elapsed = 0;
        end else m_elapsed++;
      end
      if (callValid) begin
        if (m_state == M_DOOR && int'(callFloor) == m_floor) reload = 1;
        else m_pend[callFloor] = 1'b1;
      end
      if (reload) m_left = DOOR_TICKS;
      if (tick) begin
        if (m_state == M_IDLE) begin
          if (old[m_floor]) arrive = 1;
          else if (any_in(old, m_floor + 1, 7)) begin m_dir = 1; m_state = M_MOVE; m_left = TRAVEL_TICKS; end
          else if (any_in(old, 0, m_floor - 1)) begin m_dir = 0; m_state = M_MOVE; m_left = TRAVEL_TICKS; end
        end else if (m_state == M_MOVE) begin
          m_left--;
          if (m_left == 0) begin
            m_floor += m_dir ? 1 : -1;
            m_left = TRAVEL_TICKS;
            if (old[m_floor]) arrive = 1;
          end
        end else if (!reload) begin
          m_left--;
          if (m_left == 0) begin
            ahd = m_dir ? any_in(old, m_floor + 1, 7) : any_in(old, 0, m_floor - 1);
            bhd = m_dir ? any_in(old, 0, m_floor - 1) : any_in(old, m_floor + 1, 7);
            if (ahd) begin m_state = M_MOVE; m_left = TRAVEL_TICKS; end
            else if (bhd) begin m_dir = 1 - m_dir; m_state = M_MOVE; m_left = TRAVEL_TICKS; end
            else m_state = M_IDLE;
          end
        end
      end
      if (arrive) begin
        m_state = M_DOOR; m_left = DOOR_TICKS; m_pend[m_floor] = 1'b0; m_arr = 1;
        if (m_served < 63) m_served++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rnd_floor", int'(floor), m_floor);
      chk("rnd_moving", int'(moving), int'(m_state == M_MOVE));
      chk("rnd_dirUp", int'(dirUp), m_dir);
      chk("rnd_doorOpen", int'(doorOpen), int'(m_state == M_DOOR));
      chk("rnd_pending", int'(pending), pend_val());
      chk("rnd_arrived", int'(arrived), m_arr);
      chk("rnd_served", int'(served), m_served);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       r;
    logic [1:0] st;
    logic       cv;
    logic [2:0] cf;
    int         cyc;
    int         fl, mv, dr, dn, pd, ar, sv;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] st, input logic cv,
                              input logic [2:0] cf, input int cyc, input int fl,
                              input int mv, input int dr, input int dn, input int pd,
                              input int ar, input int sv);
    vec_t v;
    v.r = r; v.st = st; v.cv = cv; v.cf = cf; v.cyc = cyc;
    v.fl = fl; v.mv = mv; v.dr = dr; v.dn = dn; v.pd = pd; v.ar = ar; v.sv = sv;
    return v;
  endfunction

  task automatic check_all(input string tag, input int fl, input int mv, input int dr,
                           input int dn, input int pd, input int ar, input int sv);
    chk({tag, "_floor"}, int'(floor), fl);
    chk({tag, "_moving"}, int'(moving), mv);
    chk({tag, "_dirUp"}, int'(dirUp), dr);
    chk({tag, "_doorOpen"}, int'(doorOpen), dn);
    chk({tag, "_pending"}, int'(pending), pd);
    chk({tag, "_arrived"}, int'(arrived), ar);
    chk({tag, "_served"}, int'(served), sv);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [$];

  initial begin
    int n, arrs;
    bit got, sent1;
    int stops [$];
    int dirs [$];

    rst = 1'b1; simState = 2'd0; simSpeed = 3'd7; callValid = 1'b0; callFloor = 3'd0;

    //             r  st  cv cf cyc  fl mv dr dn  pd    ar sv
    tbl.push_back(mk(1, 0, 0, 0, 2,   0, 0, 1, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 3, 1,   0, 0, 1, 0, 'h08, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3,   0, 1, 1, 0, 'h08, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8,   1, 1, 1, 0, 'h08, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8,   2, 1, 1, 0, 'h08, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 7,   2, 1, 1, 0, 'h08, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,   3, 0, 1, 1, 'h00, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1,   3, 0, 1, 1, 'h00, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 10,  3, 0, 1, 1, 'h00, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1,   3, 0, 1, 0, 'h00, 0, 1));
    tbl.push_back(mk(0, 1, 1, 3, 1,   3, 0, 1, 0, 'h08, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 2,   3, 0, 1, 0, 'h08, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1,   3, 0, 1, 1, 'h00, 1, 2));
    tbl.push_back(mk(0, 1, 0, 0, 4,   3, 0, 1, 1, 'h00, 0, 2));
    tbl.push_back(mk(0, 1, 1, 3, 1,   3, 0, 1, 1, 'h00, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 10,  3, 0, 1, 1, 'h00, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1,   3, 0, 1, 0, 'h00, 0, 2));
    tbl.push_back(mk(0, 1, 1, 6, 1,   3, 0, 1, 0, 'h40, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 3,   3, 1, 1, 0, 'h40, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 9,   4, 1, 1, 0, 'h40, 0, 2));
    tbl.push_back(mk(1, 1, 1, 5, 1,   0, 0, 1, 0, 'h00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; simState = tbl[i].st; callValid = tbl[i].cv; callFloor = tbl[i].cf;
      repeat (tbl[i].cyc) @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), tbl[i].fl, tbl[i].mv, tbl[i].dr, tbl[i].dn,
                tbl[i].pd, tbl[i].ar, tbl[i].sv);
    end

    // Pause mid-travel must not change the remaining cycle count
    rst = 1'b0; simState = 2'd1; callValid = 1'b1; callFloor = 3'd2;
    edge1();
    callValid = 1'b0;
    repeat (9) edge1();
    simState = 2'd2;
    repeat (50) edge1();
    chk("pause_floor", int'(floor), 0);
    chk("pause_moving", int'(moving), 1);
    chk("pause_pending", int'(pending), 'h04);
    simState = 2'd1;
    n = 0; got = 0;
    while (!got && n < 100) begin
      edge1(); n++;
      if (arrived) got = 1;
    end
    chk("pause_resume_cycles", got ? n : -1, 10);
    chk("pause_resume_floor", int'(floor), 2);

    // Up-sweep with a call behind the car arriving mid-sweep
    rst = 1'b1; edge1(); rst = 1'b0;
    callValid = 1'b1; callFloor = 3'd5; edge1();
    callFloor = 3'd2; edge1();
    callValid = 1'b0;
    n = 0; sent1 = 0;
    while (stops.size() < 3 && n < 800) begin
      edge1(); n++;
      if (arrived) begin stops.push_back(int'(floor)); dirs.push_back(int'(dirUp)); end
      if (!sent1 && floor == 3'd2 && doorOpen) begin
        callValid = 1'b1; callFloor = 3'd1; sent1 = 1;
      end else callValid = 1'b0;
    end
    chk("sweep_stop_count", stops.size(), 3);
    chk("sweep_stop0", stops.size() > 0 ? stops[0] : -1, 2);
    chk("sweep_stop1", stops.size() > 1 ? stops[1] : -1, 5);
    chk("sweep_stop2", stops.size() > 2 ? stops[2] : -1, 1);
    chk("sweep_dir_at_stop2", dirs.size() > 2 ? dirs[2] : -1, 0);
    chk("sweep_served", int'(served), 3);

    // ENDING wipes state, and ignores a concurrent call
    rst = 1'b1; edge1(); rst = 1'b0;
    callValid = 1'b1; callFloor = 3'd2; edge1();
    callFloor = 3'd5; edge1();
    chk("ending_pre_pending", int'(pending), 'h24);
    simState = 2'd3; callFloor = 3'd7; edge1();
    check_all("ending", 0, 0, 1, 0, 'h00, 0, 0);

    // Slowest speed: one tick every 32 cycles
    simState = 2'd1; simSpeed = 3'd0; callValid = 1'b1; callFloor = 3'd1;
    n = 0; got = 0;
    while (!got && n < 100) begin
      edge1(); n++; callValid = 1'b0;
      if (moving) got = 1;
    end
    chk("slow_first_tick", got ? n : -1, 32);
    n = 0; got = 0;
    while (!got && n < 200) begin
      edge1(); n++;
      if (floor == 3'd1) got = 1;
    end
    chk("slow_floor_step", got ? n : -1, 64);

    // served saturates at 63
    simSpeed = 3'd7; rst = 1'b1; edge1(); rst = 1'b0;
    n = 0; arrs = 0;
    while (arrs < 66 && n < 4000) begin
      edge1(); n++;
      if (arrived) arrs++;
      if (!moving && !doorOpen && pending == 8'h00 && !callValid) begin
        callValid = 1'b1; callFloor = 3'd0;
      end else callValid = 1'b0;
    end
    chk("sat_arrivals", arrs, 66);
    chk("sat_served", int'(served), 63);

    // Randomized phase against the reference model
    callValid = 1'b0; rst = 1'b1; simState = 2'd1; edge1(); rst = 1'b0;
    cmp_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) < 5) begin
        r = $urandom_range(0, 99);
        simState = (r < 80) ? 2'd1 : (r < 94) ? 2'd2 : (r < 97) ? 2'd0 : 2'd3;
      end
      if ($urandom_range(0, 99) < 5) simSpeed = 3'($urandom_range(0, 7));
      callValid = ($urandom_range(0, 9) < 2);
      callFloor = 3'($urandom_range(0, 7));
      edge1();
    end
    @(posedge clk);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
